// File: rtl/seq_arithmetic_unit.sv
// Sequential add/sub/shift-add multiply/restoring divide unit with a registered 2*WIDTH result.
// Optional divider datapath is compiled in with macro SEQ_AU_DIV_EN.
module seq_arithmetic_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         op,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one multiply/divide iteration per cycle, busy=1
  // DONE  | done pulse, result valid; start re-accepted here
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH:0]       add_sum, sub_diff, mul_sum;
  logic [2*WIDTH-1:0]   mul_next, calc_next;
  logic                 accept;

`ifdef SEQ_AU_DIV_EN
  logic                 is_div_q, is_div_d;
  logic [WIDTH:0]       div_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef SEQ_AU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef SEQ_AU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  always_comb begin
    add_sum  = {1'b0, A} + {1'b0, B};
    sub_diff = {1'b0, A} - {1'b0, B};
    // Shift-add: upper half accumulates, multiplier bits retire from the LSB.
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, p_q[WIDTH-1:1]};
`ifdef SEQ_AU_DIV_EN
    // Restoring divide: p holds {remainder, dividend/quotient}, quotient bit enters at LSB.
    div_sh   = p_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_rem  = div_sh[WIDTH-1:0] - opnd_q;
    div_next = {(div_ge ? div_rem : div_sh[WIDTH-1:0]), p_q[WIDTH-2:0], div_ge};
    calc_next = is_div_q ? div_next : mul_next;
`else
    calc_next = mul_next;
`endif
    accept = start && (state_q != CALC);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    ovf_d    = ovf_q;
`ifdef SEQ_AU_DIV_EN
    is_div_d = is_div_q;
`endif
    case (state_q)
      CALC: begin
        p_d   = calc_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          result_d = calc_next;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          case (op)
            2'b00: begin
              result_d = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
              ovf_d    = add_sum[WIDTH];
              state_d  = DONE;
            end
            2'b01: begin
              result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
              ovf_d    = sub_diff[WIDTH];
              state_d  = DONE;
            end
            2'b10: begin
              p_d     = {{WIDTH{1'b0}}, B};
              opnd_d  = A;
              cnt_d   = CW'(WIDTH);
              state_d = CALC;
`ifdef SEQ_AU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
            default: begin
`ifdef SEQ_AU_DIV_EN
              if (B == '0) begin
                result_d = {A, {WIDTH{1'b1}}};
                ovf_d    = 1'b1;
                state_d  = DONE;
              end else begin
                p_d      = {{WIDTH{1'b0}}, A};
                opnd_d   = B;
                cnt_d    = CW'(WIDTH);
                is_div_d = 1'b1;
                state_d  = CALC;
              end
`else
              result_d = '0;
              ovf_d    = 1'b1;
              state_d  = DONE;
`endif
            end
          endcase
        end
      end
    endcase
    zero_d = (result_d == '0);
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_arithmetic_unit.sv
// Self-checking bench for seq_arithmetic_unit (WIDTH=4): directed cases plus random ops vs. an arithmetic model.
module tb_seq_arithmetic_unit;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [1:0]     op = '0;
  logic           busy, done, zero, overflow;
  logic [2*W-1:0] result;

  int errors = 0;
  int checks = 0;

  seq_arithmetic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .op(op),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic.
  task automatic model(input int a, input int b, input int o,
                       output int res, output int ovf, output int lat, output int nbusy);
    int m;
    m = 2 ** W;
    lat = 1; nbusy = 0; ovf = 0;
    case (o)
      0: begin res = (a + b) % m; ovf = (a + b >= m) ? 1 : 0; end
      1: begin res = (a - b + m) % m; ovf = (a < b) ? 1 : 0; end
      2: begin res = a * b; lat = W + 1; nbusy = W; end
      default: begin
`ifdef SEQ_AU_DIV_EN
        if (b == 0) begin res = a * m + (m - 1); ovf = 1; end
        else begin res = (a % b) * m + a / b; lat = W + 1; nbusy = W; end
`else
        res = 0; ovf = 1;
`endif
      end
    endcase
  endtask

  task automatic run_op(input int a, input int b, input int o, input bit glitch, input string tag);
    int er, eo, el, eb, cyc, nb;
    model(a, b, o, er, eo, el, eb);
    @(negedge clk);
    A = a[W-1:0]; B = b[W-1:0]; op = o[1:0]; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = ~A; B = ~B; op = ~op;
    cyc = 1; nb = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (glitch && cyc == 2) begin
        start = 1'b1; A = 4'd1; B = 4'd1; op = 2'b00;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, " latency"}, cyc, el);
    chk({tag, " busy_cycles"}, nb, eb);
    chk({tag, " result"}, int'(result), er);
    chk({tag, " overflow"}, int'(overflow), eo);
    chk({tag, " zero"}, int'(zero), (er == 0) ? 1 : 0);
    @(negedge clk);
    chk({tag, " done_width"}, int'(done), 0);
    chk({tag, " result_hold"}, int'(result), er);
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset result", int'(result), 0);
    chk("reset zero", int'(zero), 1);
    chk("reset overflow", int'(overflow), 0);
    rst = 1'b0;

    run_op(9, 8, 0, 1'b0, "add_9_8");
    run_op(3, 5, 1, 1'b0, "sub_3_5");

    // Reset two cycles into a multiply.
    @(negedge clk);
    A = 4'd15; B = 4'd15; op = 2'b10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst result", int'(result), 0);
    chk("midrst zero", int'(zero), 1);
    chk("midrst overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst no_done", ndone, 0);

    run_op(5, 5, 1, 1'b0, "sub_5_5");
    run_op(15, 15, 2, 1'b1, "mul_15_15_glitch");
    run_op(13, 4, 3, 1'b0, "div_13_4");
    run_op(7, 0, 3, 1'b0, "div_7_0");
    run_op(0, 0, 0, 1'b0, "add_0_0");
    run_op(15, 1, 0, 1'b0, "add_15_1");
    run_op(0, 9, 2, 1'b0, "mul_0_9");
    run_op(15, 1, 3, 1'b0, "div_15_1");

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_arithmetic_unit.md
SEQ_ARITHMETIC_UNIT -- requirements
Module: seq_arithmetic_unit

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request strobe; accepted only when busy=0.
REQ-005 Port: A  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 Port: B  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 Port: op  input  2  operation code: 00 add, 01 sub, 10 mul, 11 div; sampled on the accepting edge.
REQ-008 Port: busy  output  1  high while an iterative operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result, zero and overflow are valid.
REQ-010 Port: result  output  2*WIDTH  registered result.
REQ-011 Port: zero  output  1  high when result is all zeros.
REQ-012 Port: overflow  output  1  error/overflow flag for the completed operation.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; busy=1 only in CALC.
REQ-014 Transitions: on an accepted start, add/sub go to DONE, and mul/div go to CALC (or to DONE immediately on divide-by-zero); CALC goes to DONE after exactly WIDTH iterations; DONE goes to IDLE, or is re-accepted on start.
REQ-015 A start in IDLE or DONE SHALL be accepted; a start while busy=1 SHALL be ignored with no effect on the operands or the result.
REQ-016 Latency from the accepting edge to done high: 1 cycle for add/sub/div-by-zero; WIDTH+1 cycles for mul/div.
REQ-017 done SHALL be high exactly one cycle per accepted operation.
REQ-018 result, zero and overflow SHALL hold their values from done until the next done or reset.
REQ-019 Add: result = {WIDTH zeros, (A+B) mod 2^WIDTH}; overflow = carry out.
REQ-020 Sub: result = {WIDTH zeros, (A-B) mod 2^WIDTH}; overflow = borrow (A<B).
REQ-021 Mul: unsigned shift-add, one partial product per CALC cycle; result = A*B over the full 2*WIDTH bits; overflow = 0.
REQ-022 Div: unsigned restoring division, one quotient bit per CALC cycle, MSB first; result = {remainder, quotient}; overflow = 0.
REQ-023 Divide-by-zero (B=0): result = {A, all ones}; overflow = 1; no CALC cycles.
REQ-024 zero SHALL be registered together with result and computed from the new result value.
REQ-025 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-026 Asserting rst at any time, including mid-CALC, SHALL immediately force the following: state IDLE, busy=0, done=0, result=0, zero=1, overflow=0, and counter/shadow registers cleared.
REQ-027 An operation interrupted by reset SHALL produce no done pulse.
REQ-028 The first start after rst deasserts SHALL be accepted normally on the next rising edge.

Configuration
REQ-029 The macro SEQ_AU_DIV_EN SHALL compile the divider datapath in or out.
REQ-030 With SEQ_AU_DIV_EN defined, op=11 SHALL behave per REQ-022 and REQ-023.
REQ-031 Without SEQ_AU_DIV_EN, op=11 SHALL complete with 1-cycle latency, result=0, zero=1, overflow=1, and no divider logic synthesised.

Verification (WIDTH=4, SEQ_AU_DIV_EN defined unless noted)
REQ-032 Add: start with A=9, B=8, op=00 -> done 1 cycle later; result=0x01, overflow=1, zero=0.
REQ-033 Sub: A=3, B=5, op=01 -> result=0x0E, overflow=1; then A=5, B=5 -> result=0x00, zero=1, overflow=0.
REQ-034 Mul: A=15, B=15, op=10 -> busy for 4 cycles, done 5 cycles after start; result=0xE1, overflow=0; a start pulse during busy is ignored.
REQ-035 Div: A=13, B=4, op=11 -> done 5 cycles after start, result=0x13; A=7, B=0 -> done 1 cycle later, result=0x7F, overflow=1.
REQ-036 Reset: assert rst 2 cycles into the A=15, B=15 mul -> busy=0 and result=0 immediately, zero=1, and no done pulse follows.
REQ-037 Build without SEQ_AU_DIV_EN: A=13, B=4, op=11 -> done 1 cycle later; result=0x00, zero=1, overflow=1.
